// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: decode/memory-side inputs and forwarding/stall outputs of the hazard controller
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
);
  logic                  dec_valid;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic                  dec_use_rs1;
  logic                  dec_use_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_reg_write;
  logic                  dec_is_load;
  logic                  flush;
  logic                  mem_ready;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  hold_front;
  logic                  idex_bubble;
  logic                  pipe_freeze;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_cycles;
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_reg_write, dec_is_load, flush, mem_ready,
    input  fwd_a_sel, fwd_b_sel, hold_front, idex_bubble, pipe_freeze,
           ctrl_state, stall_cycles
  );
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
           dec_reg_write, dec_is_load, flush, mem_ready,
    output fwd_a_sel, fwd_b_sel, hold_front, idex_bubble, pipe_freeze,
           ctrl_state, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX/MEM shadow scoreboard driving operand forwarding selects,
// load-use bubbles, data-memory wait freezes and branch flushes for a 5-stage RV32I pipe.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  fwd_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } slot_t;
  typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, MWAIT = 2'd2} state_t;
  slot_t            ex_q;
  slot_t            mem_q;
  slot_t            dec_s;
  logic [1:0]       sel_a_q;
  logic [1:0]       sel_b_q;
  logic [CNT_W-1:0] cnt_q;
  state_t           state_q;
  state_t           state_c;
  logic             freeze;
  logic             luh;
  logic             squash;
  function automatic logic writes(slot_t s, logic [REG_ADDR_W-1:0] r);
    return s.v & s.we & (s.rd == r) & (|s.rd);
  endfunction
  // EX holds the younger producer, so it is checked first
  function automatic logic [1:0] sel_for(slot_t ex, slot_t mem, logic use_r, logic [REG_ADDR_W-1:0] r);
    return !use_r ? 2'b00 : writes(ex, r) ? 2'b10 : writes(mem, r) ? 2'b01 : 2'b00;
  endfunction
  assign dec_s = '{v: bus.dec_valid, rd: bus.dec_rd, we: bus.dec_reg_write, ld: bus.dec_is_load};
  assign freeze = mem_q.v & mem_q.ld & ~bus.mem_ready;
  assign luh = bus.dec_valid & ~bus.flush & ex_q.ld &
               ((bus.dec_use_rs1 & writes(ex_q, bus.dec_rs1)) |
                (bus.dec_use_rs2 & writes(ex_q, bus.dec_rs2)));
  assign squash = bus.flush | luh;
  always_comb state_c = freeze ? MWAIT : luh ? LDSTALL : RUN;
  assign bus.pipe_freeze  = freeze;
  assign bus.hold_front   = freeze | luh;
  assign bus.idex_bubble  = ~freeze & squash;
  assign bus.ctrl_state   = state_c;
  assign bus.fwd_a_sel    = sel_a_q;
  assign bus.fwd_b_sel    = sel_b_q;
  assign bus.stall_cycles = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      sel_a_q <= 2'b00;
      sel_b_q <= 2'b00;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      state_q <= state_c;
      if ((freeze | luh) && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      if (!freeze) begin
        mem_q   <= ex_q;
        ex_q    <= squash ? '0 : dec_s;
        sel_a_q <= squash ? 2'b00 : sel_for(ex_q, mem_q, bus.dec_use_rs1, bus.dec_rs1);
        sel_b_q <= squash ? 2'b00 : sel_for(ex_q, mem_q, bus.dec_use_rs2, bus.dec_rs2);
      end
    end
  end
  // after a bubble the load sits in MEM, so a back-to-back load-use stall is impossible
  always_ff @(posedge clk) begin
    if (rst_n && state_q == LDSTALL && !freeze) assert (!luh);
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed pins plus randomized traffic checked against an instruction-level pipeline model
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;
  fwd_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();
  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // stg[0] is the instruction in EX, stg[1] the one in MEM
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } ins_t;
  ins_t stg[2];
  int m_a = 0;
  int m_b = 0;
  int m_cnt = 0;
  function automatic bit wr(ins_t s, int r);
    return s.v && s.we && s.rd == r && r != 0;
  endfunction
  function automatic bit m_frz();
    return stg[1].v && stg[1].ld && !bus.mem_ready;
  endfunction
  function automatic bit m_luh();
    return bus.dec_valid && !bus.flush && stg[0].ld &&
           ((bus.dec_use_rs1 && wr(stg[0], int'(bus.dec_rs1))) ||
            (bus.dec_use_rs2 && wr(stg[0], int'(bus.dec_rs2))));
  endfunction
  // the nearest producer ahead of the consumer decides: distance 1 -> 2 (EX/MEM), distance 2 -> 1 (MEM/WB)
  function automatic int m_sel(bit u, int r);
    if (u) for (int i = 0; i < 2; i++) if (wr(stg[i], r)) return 2 - i;
    return 0;
  endfunction
  always @(posedge clk) begin
    bit f;
    bit l;
    f = m_frz();
    l = m_luh();
    if (!rst_n) begin
      stg[0] = '{default: 0};
      stg[1] = '{default: 0};
      m_a = 0;
      m_b = 0;
      m_cnt = 0;
    end else begin
      if (f || l) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      if (!f) begin
        if (bus.flush || l) begin
          m_a = 0;
          m_b = 0;
          stg[1] = stg[0];
          stg[0] = '{default: 0};
        end else begin
          m_a = m_sel(bus.dec_use_rs1, int'(bus.dec_rs1));
          m_b = m_sel(bus.dec_use_rs2, int'(bus.dec_rs2));
          stg[1] = stg[0];
          stg[0] = '{v: bus.dec_valid, rd: int'(bus.dec_rd), we: bus.dec_reg_write, ld: bus.dec_is_load};
        end
      end
    end
  end
  task automatic lit(string n, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    bit f;
    bit l;
    if (chk_on) begin
      f = m_frz();
      l = m_luh();
      lit("pipe_freeze", 32'(bus.pipe_freeze), 32'(f));
      lit("hold_front", 32'(bus.hold_front), 32'(f || l));
      lit("idex_bubble", 32'(bus.idex_bubble), 32'(!f && (bus.flush || l)));
      lit("ctrl_state", 32'(bus.ctrl_state), f ? 2 : l ? 1 : 0);
      lit("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(m_a));
      lit("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(m_b));
      lit("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic put(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit we, bit ld);
    bus.dec_valid = v;
    bus.dec_rd = AW'(rd);
    bus.dec_rs1 = AW'(rs1);
    bus.dec_rs2 = AW'(rs2);
    bus.dec_use_rs1 = u1;
    bus.dec_use_rs2 = u2;
    bus.dec_reg_write = we;
    bus.dec_is_load = ld;
  endtask
  task automatic nop();
    put(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask
  int s0;
  initial begin
    rst_n = 0;
    nop();
    bus.flush = 0;
    bus.mem_ready = 1;
    cyc();
    chk_on = 1;
    cyc();
    #2;
    lit("rst fwd_a", 32'(bus.fwd_a_sel), 0);
    lit("rst fwd_b", 32'(bus.fwd_b_sel), 0);
    lit("rst stall", 32'(bus.stall_cycles), 0);
    lit("rst state", 32'(bus.ctrl_state), 0);
    lit("rst hold", 32'(bus.hold_front), 0);
    rst_n = 1;
    // add x1 ; add x2,x1,x1
    put(1, 1, 0, 0, 0, 0, 1, 0); cyc();
    put(1, 2, 1, 1, 1, 1, 1, 0); cyc();
    nop(); #2;
    lit("exfwd a", 32'(bus.fwd_a_sel), 2);
    lit("exfwd b", 32'(bus.fwd_b_sel), 2);
    // x1 produced in both EX and MEM: youngest wins
    put(1, 1, 0, 0, 0, 0, 1, 0); cyc();
    put(1, 1, 0, 0, 0, 0, 1, 0); cyc();
    put(1, 2, 1, 1, 1, 1, 1, 0); cyc();
    nop(); #2;
    lit("both a", 32'(bus.fwd_a_sel), 2);
    lit("both b", 32'(bus.fwd_b_sel), 2);
    // add x3 ; nop ; sub x4,x3,x0
    put(1, 3, 0, 0, 0, 0, 1, 0); cyc();
    nop(); cyc();
    put(1, 4, 3, 0, 1, 1, 1, 0); cyc();
    nop(); #2;
    lit("memfwd a", 32'(bus.fwd_a_sel), 1);
    lit("memfwd b", 32'(bus.fwd_b_sel), 0);
    // lw x5 ; add x6,x5,x5
    do_reset();
    put(1, 5, 0, 0, 1, 0, 1, 1); cyc();
    put(1, 6, 5, 5, 1, 1, 1, 0); #2;
    lit("luh hold", 32'(bus.hold_front), 1);
    lit("luh bubble", 32'(bus.idex_bubble), 1);
    lit("luh state", 32'(bus.ctrl_state), 1);
    cyc(); #2;
    lit("post-luh hold", 32'(bus.hold_front), 0);
    cyc();
    nop(); #2;
    lit("luh fwd a", 32'(bus.fwd_a_sel), 1);
    lit("luh fwd b", 32'(bus.fwd_b_sel), 1);
    lit("luh stall", 32'(bus.stall_cycles), 1);
    // addi x0 ; add x7,x0,x0
    put(1, 0, 0, 0, 1, 0, 1, 0); cyc();
    put(1, 7, 0, 0, 1, 1, 1, 0); #2;
    lit("x0 hold", 32'(bus.hold_front), 0);
    cyc();
    nop(); #2;
    lit("x0 fwd a", 32'(bus.fwd_a_sel), 0);
    lit("x0 fwd b", 32'(bus.fwd_b_sel), 0);
    // add x8 ; lw x5 ; add x9,x8 then 3 wait states with flush pending
    do_reset();
    put(1, 8, 0, 0, 0, 0, 1, 0); cyc();
    put(1, 5, 0, 0, 0, 0, 1, 1); cyc();
    put(1, 9, 8, 0, 1, 0, 1, 0); cyc();
    nop();
    bus.flush = 1;
    bus.mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      lit("frz freeze", 32'(bus.pipe_freeze), 1);
      lit("frz state", 32'(bus.ctrl_state), 2);
      lit("frz bubble", 32'(bus.idex_bubble), 0);
      lit("frz fwd a", 32'(bus.fwd_a_sel), 1);
      cyc();
    end
    bus.mem_ready = 1; #2;
    lit("post-frz bubble", 32'(bus.idex_bubble), 1);
    lit("post-frz hold", 32'(bus.hold_front), 0);
    lit("frz stall", 32'(bus.stall_cycles), 3);
    cyc();
    bus.flush = 0; #2;
    lit("post-flush fwd a", 32'(bus.fwd_a_sel), 0);
    // flush together with load-use: flush wins
    s0 = int'(bus.stall_cycles);
    put(1, 9, 0, 0, 0, 0, 1, 1); cyc();
    put(1, 10, 9, 0, 1, 0, 1, 0);
    bus.flush = 1; #2;
    lit("fl hold", 32'(bus.hold_front), 0);
    lit("fl bubble", 32'(bus.idex_bubble), 1);
    lit("fl state", 32'(bus.ctrl_state), 0);
    cyc();
    bus.flush = 0;
    put(1, 11, 9, 0, 1, 0, 1, 0); #2;
    lit("fl ex invalid", 32'(bus.hold_front), 0);
    lit("fl sel", 32'(bus.fwd_a_sel), 0);
    lit("fl stall", 32'(bus.stall_cycles), 32'(s0));
    cyc();
    nop(); #2;
    lit("fl memfwd", 32'(bus.fwd_a_sel), 1);
    // reset in the middle of a wait state
    put(1, 5, 0, 0, 0, 0, 1, 1); cyc();
    nop(); cyc();
    bus.mem_ready = 0; #2;
    lit("mw freeze", 32'(bus.pipe_freeze), 1);
    cyc();
    do_reset(); #2;
    lit("mw rst freeze", 32'(bus.pipe_freeze), 0);
    lit("mw rst state", 32'(bus.ctrl_state), 0);
    lit("mw rst stall", 32'(bus.stall_cycles), 0);
    lit("mw rst hold", 32'(bus.hold_front), 0);
    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      put($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    rst_n = 1;
    nop();
    bus.flush = 0;
    bus.mem_ready = 1;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
